regfile_wb: RTL

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/regfile_wb_if.sv | 37 +++
 rtl/regfile_wb.sv | 124 ++++++++++++
 2 files changed

// File: rtl/regfile_wb_if.sv
// Bus bundle for regfile_wb: ALU result port, load-return handshake port and
// the registered register-file write port.
// Handshake: a load return transfers on a rising clk edge where mem_valid and
// mem_ready are both high; mem_ready depends only on registered state, and
// alu_valid is never back-pressured.
interface regfile_wb_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          busy;

    // Write-back block side
    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        output we, w_addr, w_data, busy
    );

    // Producer / observer side
    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        input  we, w_addr, w_data, busy
    );
endinterface

// File: rtl/regfile_wb.sv
// Register-file write-back arbiter. ALU results write immediately (one edge
// later); load returns are buffered in a DEPTH-entry FIFO and written on
// cycles where no ALU result is present.
// Optional feature: define REGFILE_WB_SQUASH_EN to drop buffered loads whose
// destination is overwritten by a younger ALU result (write-after-write).
module regfile_wb #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic        clk,
    input  logic        rst,
    regfile_wb_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic          push;
    logic          pop;
    logic          head_squashed;
    logic          we_q;
    logic [AW-1:0] w_addr_q;
    logic [DW-1:0] w_data_q;

    // Ready and busy come from the registered count only, so no input can
    // reach them combinationally; a full FIFO stays not-ready during a pop.
    assign bus.mem_ready = (count < CW'(DEPTH));
    assign bus.busy      = (count != '0);
    assign bus.we        = we_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_data    = w_data_q;

    // Arbitration: ALU wins, otherwise pop a buffered load if there is one.
    always_comb begin
        push = bus.mem_valid && bus.mem_ready;
        pop  = !bus.alu_valid && (count != '0);
    end

`ifdef REGFILE_WB_SQUASH_EN
    logic [DEPTH-1:0] squash_q;
    logic [DEPTH-1:0] squash_d;

    // Mark live entries (and a same-cycle push) whose address the ALU rewrites.
    always_comb begin
        squash_d = squash_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.alu_valid && (addr_mem[i] == bus.alu_addr) &&
                (CW'(PW'(i) - rd_ptr) < count)) begin
                squash_d[i] = 1'b1;
            end
        end
        if (push) begin
            squash_d[wr_ptr] = bus.alu_valid && (bus.mem_addr == bus.alu_addr);
        end
    end

    // Squash flags are state that must clear on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            squash_q <= '0;
        end else begin
            squash_q <= squash_d;
        end
    end

    assign head_squashed = squash_q[rd_ptr];
`else
    assign head_squashed = 1'b0;
`endif

    // FIFO storage; contents need no reset because count gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= bus.mem_addr;
            data_mem[wr_ptr] <= bus.mem_data;
        end
    end

    // Pointers wrap naturally (power-of-two DEPTH); count tracks 0..DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered write port; address/data hold when nothing is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else if (bus.alu_valid) begin
            we_q     <= 1'b1;
            w_addr_q <= bus.alu_addr;
            w_data_q <= bus.alu_data;
        end else if (pop && !head_squashed) begin
            we_q     <= 1'b1;
            w_addr_q <= addr_mem[rd_ptr];
            w_data_q <= data_mem[rd_ptr];
        end else begin
            we_q     <= 1'b0;
        end
    end
endmodule
